// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core: widths, opcodes, FSM states and instruction field helpers.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned REG_W  = 2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_MOV  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMRD1 = 3'd4,
        S_MEMRD2 = 3'd5,
        S_MEMWR  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Instruction layout: [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [5:0] imm6/addr6
    function automatic logic [3:0] f_op(input logic [DATA_W-1:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [REG_W-1:0] f_rd(input logic [DATA_W-1:0] ir);
        return ir[11:10];
    endfunction

    function automatic logic [REG_W-1:0] f_rs(input logic [DATA_W-1:0] ir);
        return ir[9:8];
    endfunction

    function automatic logic [REG_W-1:0] f_rt(input logic [DATA_W-1:0] ir);
        return ir[7:6];
    endfunction

    function automatic logic [ADDR_W-1:0] f_addr(input logic [DATA_W-1:0] ir);
        return ir[5:0];
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath for the register-to-register opcodes; non-ALU opcodes yield zero.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result_c
);

    always_comb begin
        o_result_c = '0;
        case (i_op)
            OP_ADD:  o_result_c = i_a + i_b;
            OP_SUB:  o_result_c = i_a - i_b;
            OP_AND:  o_result_c = i_a & i_b;
            OP_OR:   o_result_c = i_a | i_b;
            OP_XOR:  o_result_c = i_a ^ i_b;
            OP_NOT:  o_result_c = ~i_a;
            OP_SHL:  o_result_c = {i_a[DATA_W-2:0], 1'b0};
            OP_SHR:  o_result_c = {1'b0, i_a[DATA_W-1:1]};
            OP_MOV:  o_result_c = i_a;
            default: o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit core: FSM, PC, IR and 4-entry register file; ROM/RAM live outside.
module cpu
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_from_rom,
    inout  wire  [DATA_W-1:0] data_ram,
    output logic [ADDR_W-1:0] address_to_rom,
    output logic              enable_to_rom,
    output logic              write_enable_to_ram,
    output logic [ADDR_W-1:0] address_to_ram,
    output logic              read_enable_to_ram,
    output logic              enable_ram_read
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_regs [4];
    logic              r_en_rom;
    logic              r_we_ram;
    logic              r_re_ram;
    logic              r_oe_ram;
    logic [ADDR_W-1:0] r_addr_ram;
    logic [DATA_W-1:0] r_wdata;

    logic [3:0]        w_op;
    logic [REG_W-1:0]  w_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;

    assign w_op   = f_op(r_ir);
    assign w_rd   = f_rd(r_ir);
    assign w_addr = f_addr(r_ir);
    assign w_a    = r_regs[f_rs(r_ir)];
    assign w_b    = r_regs[f_rt(r_ir)];

    cpu_alu u_alu (
        .i_op       (w_op),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_result_c (w_alu)
    );

    assign address_to_rom      = r_pc;
    assign enable_to_rom       = r_en_rom;
    assign write_enable_to_ram = r_we_ram;
    assign read_enable_to_ram  = r_re_ram;
    assign enable_ram_read     = r_oe_ram;
    assign address_to_ram      = r_addr_ram;
    assign data_ram            = r_we_ram ? r_wdata : {DATA_W{1'bz}};

    // Strobes are set on entry to the state that owns them, so they line up with r_state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_RESET;
            r_pc       <= '0;
            r_ir       <= '0;
            r_en_rom   <= 1'b0;
            r_we_ram   <= 1'b0;
            r_re_ram   <= 1'b0;
            r_oe_ram   <= 1'b0;
            r_addr_ram <= '0;
            r_wdata    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_en_rom   <= 1'b0;
            r_we_ram   <= 1'b0;
            r_re_ram   <= 1'b0;
            r_oe_ram   <= 1'b0;
            r_addr_ram <= '0;
            case (r_state)
                S_RESET: begin
                    r_state  <= S_FETCH;
                    r_en_rom <= 1'b1;
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= data_from_rom;
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state  <= S_FETCH;
                    r_en_rom <= 1'b1;
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_NOT, OP_SHL, OP_SHR, OP_MOV: r_regs[w_rd] <= w_alu;
                        OP_LDI: r_regs[w_rd] <= DATA_W'(w_addr);
                        OP_LD: begin
                            r_state    <= S_MEMRD1;
                            r_en_rom   <= 1'b0;
                            r_re_ram   <= 1'b1;
                            r_addr_ram <= w_addr;
                        end
                        OP_ST: begin
                            r_state    <= S_MEMWR;
                            r_en_rom   <= 1'b0;
                            r_we_ram   <= 1'b1;
                            r_addr_ram <= w_addr;
                            r_wdata    <= r_regs[w_rd];
                        end
                        OP_JMP: r_pc <= w_addr;
                        OP_BZ: begin
                            if (r_regs[w_rd] == '0) begin
                                r_pc <= w_addr;
                            end
                        end
                        OP_HALT: begin
                            r_state  <= S_HALT;
                            r_en_rom <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MEMRD1: begin
                    r_state    <= S_MEMRD2;
                    r_oe_ram   <= 1'b1;
                    r_addr_ram <= w_addr;
                end
                S_MEMRD2: begin
                    r_regs[w_rd] <= data_ram;
                    r_state      <= S_FETCH;
                    r_en_rom     <= 1'b1;
                end
                S_MEMWR: begin
                    r_state  <= S_FETCH;
                    r_en_rom <= 1'b1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: ROM/RAM models, bus monitor and hand-computed expected fetch/write traces.
module tb_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_from_rom;
    wire  [15:0] data_ram;
    logic [5:0]  address_to_rom;
    logic        enable_to_rom;
    logic        write_enable_to_ram;
    logic [5:0]  address_to_ram;
    logic        read_enable_to_ram;
    logic        enable_ram_read;

    logic [15:0] rom [64];
    logic [15:0] ram [64];

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int ld_cnt   = 0;
    logic prev_re = 1'b0;
    logic prev_we = 1'b0;

    logic [5:0]  fetch_q [$];
    logic [5:0]  wa_q    [$];
    logic [15:0] wd_q    [$];

    always #5 clk = ~clk;

    cpu dut (
        .clk                 (clk),
        .reset               (reset),
        .data_from_rom       (data_from_rom),
        .data_ram            (data_ram),
        .address_to_rom      (address_to_rom),
        .enable_to_rom       (enable_to_rom),
        .write_enable_to_ram (write_enable_to_ram),
        .address_to_ram      (address_to_ram),
        .read_enable_to_ram  (read_enable_to_ram),
        .enable_ram_read     (enable_ram_read)
    );

    // ROM answers the cycle after the strobe; RAM drives the bus only when output-enabled
    always @(posedge clk) begin
        if (enable_to_rom) data_from_rom <= rom[address_to_rom];
        if (write_enable_to_ram) ram[address_to_ram] <= data_ram;
    end

    assign data_ram = enable_ram_read ? ram[address_to_ram] : 16'hzzzz;

    always @(negedge clk) begin
        if (!reset) begin
            prev_re = 1'b0;
            prev_we = 1'b0;
        end else begin
            if (enable_to_rom) fetch_q.push_back(address_to_rom);
            if (write_enable_to_ram) begin
                wa_q.push_back(address_to_ram);
                wd_q.push_back(data_ram);
            end
            if ($countones({enable_to_rom, read_enable_to_ram, enable_ram_read, write_enable_to_ram}) > 1) viol++;
            if (!write_enable_to_ram && !enable_ram_read && data_ram !== 16'hzzzz) viol++;
            if (enable_ram_read != prev_re) viol++;
            if (write_enable_to_ram && prev_we) viol++;
            if (!write_enable_to_ram && !read_enable_to_ram && !enable_ram_read && address_to_ram != 6'd0) viol++;
            if (enable_ram_read) ld_cnt++;
            prev_re = read_enable_to_ram;
            prev_we = write_enable_to_ram;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_queues();
        fetch_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    logic [5:0]  exp_f  [31];
    logic [5:0]  exp_wa [11];
    logic [15:0] exp_wd [11];
    int          quiet;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'hF000;
        rom[0]  = 16'h9405;  // LDI R1,5
        rom[1]  = 16'h9803;  // LDI R2,3
        rom[2]  = 16'h1D80;  // ADD R3,R1,R2
        rom[3]  = 16'h2180;  // SUB R0,R1,R2
        rom[4]  = 16'hB001;
        rom[5]  = 16'h2240;  // SUB R0,R2,R1
        rom[6]  = 16'hB002;
        rom[7]  = 16'hBC0A;  // ST R3,@10
        rom[8]  = 16'hA00A;  // LD R0,@10
        rom[9]  = 16'hB003;
        rom[10] = 16'h3180;  // AND
        rom[11] = 16'hB004;
        rom[12] = 16'h4180;  // OR
        rom[13] = 16'hB005;
        rom[14] = 16'h5180;  // XOR
        rom[15] = 16'hB006;
        rom[16] = 16'h6100;  // NOT R0,R1
        rom[17] = 16'hB007;
        rom[18] = 16'h7300;  // SHL R0,R3
        rom[19] = 16'hB008;
        rom[20] = 16'h8100;  // SHR R0,R1
        rom[21] = 16'hB009;
        rom[22] = 16'hE300;  // MOV R0,R3
        rom[23] = 16'hB00B;
        rom[24] = 16'h9000;  // LDI R0,0
        rom[25] = 16'hD01E;  // BZ R0,30 (taken)
        rom[26] = 16'hB40C;  // skipped trap store
        rom[30] = 16'hDC14;  // BZ R3,20 (not taken)
        rom[31] = 16'h0000;
        rom[32] = 16'hC03F;  // JMP 63
        rom[33] = 16'hB40C;
        rom[63] = 16'h0000;

        for (int i = 0; i < 26; i++) exp_f[i] = 6'(i);
        exp_f[26] = 6'd30; exp_f[27] = 6'd31; exp_f[28] = 6'd32; exp_f[29] = 6'd63; exp_f[30] = 6'd0;
        exp_wa = '{6'd1, 6'd2, 6'd10, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd11};
        exp_wd = '{16'h0002, 16'hFFFE, 16'h0008, 16'h0008, 16'h0001, 16'h0007,
                   16'h0006, 16'hFFFA, 16'h0010, 16'h0002, 16'h0008};

        reset = 1'b0;
        #8;
        check("rst_strobes", {enable_to_rom, read_enable_to_ram, enable_ram_read, write_enable_to_ram}, 0);
        check("rst_rom_addr", address_to_rom, 0);
        check("rst_ram_addr", address_to_ram, 0);
        check("rst_bus_z", (data_ram === 16'hzzzz), 1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("reset_cycle_quiet", {enable_to_rom, read_enable_to_ram, enable_ram_read, write_enable_to_ram}, 0);
        @(negedge clk);
        check("first_fetch_en", enable_to_rom, 1);
        check("first_fetch_addr", address_to_rom, 0);

        for (int i = 0; i < 400 && fetch_q.size() < 31; i++) @(negedge clk);
        check("p1_fetch_count", fetch_q.size(), 31);
        for (int i = 0; i < 31; i++)
            check($sformatf("p1_fetch[%0d]", i), (i < fetch_q.size()) ? 32'(fetch_q[i]) : 32'hDEAD, 32'(exp_f[i]));
        check("p1_write_count", wa_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("p1_wr_addr[%0d]", i), (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hDEAD, 32'(exp_wa[i]));
            check($sformatf("p1_wr_data[%0d]", i), (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hDEAD, 32'(exp_wd[i]));
        end

        // Abort an LD in MEMRD1, then restart on a program that exposes R0
        reset = 1'b0;
        rom[0] = 16'h9007;  // LDI R0,7
        rom[1] = 16'hA00A;  // LD R0,@10
        rom[2] = 16'hF000;
        repeat (2) @(negedge clk);
        clear_queues();
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 50 && !read_enable_to_ram; i++) @(negedge clk);
        check("p2_memrd1_seen", read_enable_to_ram, 1);
        reset = 1'b0;
        #1;
        check("abort_strobes", {enable_to_rom, read_enable_to_ram, enable_ram_read, write_enable_to_ram}, 0);
        check("abort_ram_addr", address_to_ram, 0);
        rom[0] = 16'hB014;  // ST R0,@20
        rom[1] = 16'hF000;  // HALT
        repeat (2) @(negedge clk);
        clear_queues();
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 50 && wa_q.size() < 1; i++) @(negedge clk);
        check("p2_restart_pc", (fetch_q.size() > 0) ? 32'(fetch_q[0]) : 32'hDEAD, 0);
        check("p2_wr_addr", (wa_q.size() > 0) ? 32'(wa_q[0]) : 32'hDEAD, 20);
        check("p2_rd_after_abort", (wd_q.size() > 0) ? 32'(wd_q[0]) : 32'hDEAD, 0);

        repeat (5) @(negedge clk);
        check("halt_fetch_count", fetch_q.size(), 2);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (|{enable_to_rom, read_enable_to_ram, enable_ram_read, write_enable_to_ram}) quiet++;
        end
        check("halt_quiet", quiet, 0);
        check("ld_read_cycles", ld_cnt, 1);
        check("bus_protocol_viol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
